// File: rtl/adc_stim_gen.sv
// Simulation stimulus source for the RX ADC input: DC/square/sawtooth/triangle
// samples with glitch-free config commit. Define ADC_STIM_NOISE_EN to add LFSR noise.
module adc_stim_gen #(
  parameter int WIDTH      = 12,
  parameter int PERIOD_W   = 16,
  parameter int NOISE_BITS = 3
) (
  input  logic                       clk_i,
  input  logic                       rstn_i,
  input  logic                       en_i,
  input  logic [1:0]                 mode_i,
  input  logic [PERIOD_W-1:0]        period_i,
  input  logic signed [WIDTH-1:0]    amp_i,
  input  logic signed [WIDTH-1:0]    offset_i,
  input  logic                       cfg_load_i,
  output logic signed [WIDTH-1:0]    adc_o,
  output logic                       valid_o,
  output logic                       wrap_o
);

  // Output handshake: valid_o is a pure strobe with no ready; adc_o carries a
  // new sample exactly in cycles where valid_o is high and holds otherwise.

  localparam int AW = WIDTH + PERIOD_W + 1;

  typedef enum logic [1:0] {
    MODE_DC     = 2'd0,
    MODE_SQUARE = 2'd1,
    MODE_SAW    = 2'd2,
    MODE_TRI    = 2'd3
  } mode_e;

  typedef struct packed {
    mode_e                    mode;
    logic [PERIOD_W-1:0]      period;
    logic signed [WIDTH-1:0]  amp;
    logic signed [WIDTH-1:0]  offset;
  } cfg_t;

  localparam logic signed [11:0]   AMP_RST = 12'sh111;
  localparam cfg_t                 CFG_RST = '{mode:   MODE_SQUARE,
                                               period: PERIOD_W'(8),
                                               amp:    WIDTH'(AMP_RST),
                                               offset: '0};
  localparam logic signed [AW-1:0] SAT_MAX = AW'((2 ** (WIDTH - 1)) - 1);
  localparam logic signed [AW-1:0] SAT_MIN = -SAT_MAX - AW'(1);

  cfg_t                    act_q, pend_q, cfg_in, cfg_new;
  logic                    pend_vld_q;
  logic [PERIOD_W-1:0]     k_q, half;
  logic signed [AW-1:0]    acc_q, acc_step, amp_x, off_x, base, noisy;
  logic signed [WIDTH-1:0] sample_sat;
  logic signed [NOISE_BITS-1:0] noise;
  logic                    k_last, do_commit;

`ifdef ADC_STIM_NOISE_EN
  // Fibonacci LFSR, taps 16,14,13,11
  logic [15:0] lfsr_q;

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      lfsr_q <= 16'hACE1;
    end else if (en_i) begin
      lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    end
  end

  assign noise = lfsr_q[NOISE_BITS-1:0];
`else
  assign noise = '0;
`endif

  always_comb begin
    cfg_in        = '0;
    cfg_in.mode   = mode_e'(mode_i);
    cfg_in.period = (period_i < PERIOD_W'(2)) ? PERIOD_W'(2) : period_i;
    cfg_in.amp    = amp_i;
    cfg_in.offset = offset_i;

    half      = act_q.period >> 1;
    k_last    = (k_q == act_q.period - PERIOD_W'(1));
    do_commit = (pend_vld_q || cfg_load_i) && (!en_i || k_last);
    cfg_new   = cfg_load_i ? cfg_in : pend_q;

    amp_x = AW'(act_q.amp);
    off_x = AW'(act_q.offset);

    base = off_x;
    case (act_q.mode)
      MODE_DC:     base = off_x;
      MODE_SQUARE: base = (k_q < half) ? off_x + amp_x : off_x;
      MODE_SAW,
      MODE_TRI:    base = acc_q;
      default:     base = off_x;
    endcase

    // Triangle descends from the midpoint onward; sawtooth always ascends
    acc_step = ((act_q.mode == MODE_TRI) && (k_q >= half)) ? acc_q - amp_x : acc_q + amp_x;

    noisy = base + AW'(noise);
    if (noisy > SAT_MAX) begin
      sample_sat = SAT_MAX[WIDTH-1:0];
    end else if (noisy < SAT_MIN) begin
      sample_sat = SAT_MIN[WIDTH-1:0];
    end else begin
      sample_sat = noisy[WIDTH-1:0];
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      act_q      <= CFG_RST;
      pend_q     <= CFG_RST;
      pend_vld_q <= 1'b0;
      k_q        <= '0;
      acc_q      <= '0;
      adc_o      <= '0;
      valid_o    <= 1'b0;
      wrap_o     <= 1'b0;
    end else begin
      valid_o <= en_i;
      wrap_o  <= en_i && (k_q == '0);
      if (en_i) begin
        adc_o <= sample_sat;
      end
      if (do_commit) begin
        act_q      <= cfg_new;
        pend_vld_q <= 1'b0;
        k_q        <= '0;
        acc_q      <= AW'(cfg_new.offset);
      end else begin
        if (cfg_load_i) begin
          pend_q     <= cfg_in;
          pend_vld_q <= 1'b1;
        end
        if (en_i) begin
          if (k_last) begin
            k_q   <= '0;
            acc_q <= off_x;
          end else begin
            k_q   <= k_q + PERIOD_W'(1);
            acc_q <= acc_step;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_adc_stim_gen.sv
// Directed bench for adc_stim_gen: a formula-based reference model feeds an
// expected-sample queue that is drained whenever the DUT presents a sample.
module tb_adc_stim_gen;

  localparam int WIDTH      = 12;
  localparam int PERIOD_W   = 16;
  localparam int NOISE_BITS = 3;
  localparam int SMAX       = (2 ** (WIDTH - 1)) - 1;
  localparam int SMIN       = -(2 ** (WIDTH - 1));

  logic                    clk = 1'b0;
  logic                    rstn = 1'b0;
  logic                    en = 1'b0;
  logic [1:0]              mode = '0;
  logic [PERIOD_W-1:0]     period = '0;
  logic signed [WIDTH-1:0] amp = '0;
  logic signed [WIDTH-1:0] offset = '0;
  logic                    cfg_load = 1'b0;
  logic signed [WIDTH-1:0] adc;
  logic                    valid;
  logic                    wrap;

  always #5 clk = ~clk;

  adc_stim_gen #(
    .WIDTH      (WIDTH),
    .PERIOD_W   (PERIOD_W),
    .NOISE_BITS (NOISE_BITS)
  ) dut (
    .clk_i      (clk),
    .rstn_i     (rstn),
    .en_i       (en),
    .mode_i     (mode),
    .period_i   (period),
    .amp_i      (amp),
    .offset_i   (offset),
    .cfg_load_i (cfg_load),
    .adc_o      (adc),
    .valid_o    (valid),
    .wrap_o     (wrap)
  );

  // {wrap, sample}
  logic [WIDTH:0] exp_q[$];
  int n_cmp = 0;
  int n_err = 0;

  int m_mode, m_p, m_amp, m_off, m_k;
  int p_mode, p_p, p_amp, p_off;
  bit m_pend;
  logic signed [WIDTH-1:0] last_adc = '0;

  function automatic logic signed [WIDTH-1:0] sample_f(int md, int p, int a, int o, int k);
    int h = p / 2;
    int v;
    case (md)
      0:       v = o;
      1:       v = (k < h) ? o + a : o;
      2:       v = o + a * k;
      default: v = (k <= h) ? o + a * k : o + a * (2 * h - k);
    endcase
    if (v > SMAX) v = SMAX;
    if (v < SMIN) v = SMIN;
    return v[WIDTH-1:0];
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] expv);
    n_cmp++;
    assert (got === expv) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, expv);
    end
  endtask

  task automatic model_reset();
    m_mode = 1; m_p = 8; m_amp = 'h111; m_off = 0; m_k = 0; m_pend = 0;
    exp_q.delete();
    last_adc = '0;
  endtask

  task automatic apply_pending();
    m_mode = p_mode; m_p = p_p; m_amp = p_amp; m_off = p_off; m_pend = 0;
  endtask

  task automatic load(input int md, input int p, input int a, input int o);
    mode     = md[1:0];
    period   = p[PERIOD_W-1:0];
    amp      = a[WIDTH-1:0];
    offset   = o[WIDTH-1:0];
    cfg_load = 1'b1;
    p_mode = md; p_p = (p < 2) ? 2 : p; p_amp = a; p_off = o;
    m_pend = 1;
  endtask

  task automatic tick(input bit en_v);
    logic [WIDTH:0] e;
    en = en_v;
    if (en_v) begin
      exp_q.push_back({(m_k == 0), sample_f(m_mode, m_p, m_amp, m_off, m_k)});
      if (m_k == m_p - 1) begin
        m_k = 0;
        if (m_pend) apply_pending();
      end else begin
        m_k++;
      end
    end else if (m_pend) begin
      apply_pending();
      m_k = 0;
    end
    @(posedge clk);
    #1;
    cfg_load = 1'b0;
    if (en_v) begin
      check("valid_on", 32'(valid), 32'd1);
      if (exp_q.size() == 0) begin
        check("queue_underflow", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("adc", 32'(unsigned'(adc)), 32'(e[WIDTH-1:0]));
        check("wrap", 32'(wrap), 32'(e[WIDTH]));
      end
    end else begin
      check("valid_off", 32'(valid), 32'd0);
      check("wrap_off", 32'(wrap), 32'd0);
      check("adc_hold", 32'(unsigned'(adc)), 32'(unsigned'(last_adc)));
    end
    last_adc = adc;
  endtask

  // A simultaneous cfg_load must be discarded by reset
  task automatic do_reset(input bit with_load);
    en   = 1'b0;
    rstn = 1'b0;
    if (with_load) begin
      mode = 2'd0; period = 16'd3; offset = 12'sd99; cfg_load = 1'b1;
    end
    @(posedge clk);
    #1;
    rstn     = 1'b1;
    cfg_load = 1'b0;
    check("rst_adc", 32'(unsigned'(adc)), 32'd0);
    check("rst_valid", 32'(valid), 32'd0);
    check("rst_wrap", 32'(wrap), 32'd0);
    model_reset();
  endtask

  initial begin
    do_reset(1'b0);
    // default square: 0x111 x4, 0 x4
    repeat (16) tick(1'b1);
    // sawtooth
    load(2, 4, 100, -50); tick(1'b0);
    repeat (8) tick(1'b1);
    // triangle
    load(3, 6, 10, 0); tick(1'b0);
    repeat (12) tick(1'b1);
    // saturation
    load(2, 4, 2047, 0); tick(1'b0);
    repeat (8) tick(1'b1);
    // period clamp
    load(1, 0, 5, 0); tick(1'b0);
    repeat (6) tick(1'b1);
    // mid-period load switches at the next wrap
    load(1, 8, 'h111, 0); tick(1'b0);
    repeat (2) tick(1'b1);
    load(0, 8, 0, 7);
    repeat (14) tick(1'b1);
    // period change lands on the next boundary
    load(1, 8, 'h111, 0); tick(1'b0);
    tick(1'b1);
    load(1, 4, 'h111, 0);
    repeat (15) tick(1'b1);
    // enable gap at k = 5
    load(1, 8, 'h111, 0); tick(1'b0);
    repeat (5) tick(1'b1);
    repeat (3) tick(1'b0);
    repeat (5) tick(1'b1);
    // reset mid-period with a pending load, plus load during reset
    load(0, 8, 0, 99);
    tick(1'b1);
    tick(1'b1);
    do_reset(1'b1);
    repeat (8) tick(1'b1);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/adc_stim_gen.md
# adc_stim_gen

Parametrised simulation-only stimulus source that replaces the fixed square-wave ADC model in the RX chain. It produces signed samples of configurable width in one of four waveform modes (DC, square, sawtooth, triangle), with runtime period, amplitude and offset. Configuration changes are glitch-free, committed only on period boundaries. It drives the RX front end's ADC sample input, with a sample-valid strobe and a period-start marker for testbench alignment.

## Interface
- WIDTH, 12, sample width (signed two's complement)
- PERIOD_W, 16, width of period and phase counters
- NOISE_BITS, 3, noise magnitude bits (used only when ADC_STIM_NOISE_EN is defined)

- clk_i  in  1  sample clock (62.5 MHz nominal)
- rstn_i  in  1  reset; synchronous, active-low
- en_i  in  1  advance one sample per cycle when high; hold when low
- mode_i  in  2  0 = DC, 1 = square, 2 = sawtooth, 3 = triangle
- period_i  in  PERIOD_W  samples per period P; values below 2 clamp to 2
- amp_i  in  WIDTH  signed amplitude/step
- offset_i  in  WIDTH  signed offset
- cfg_load_i  in  1  one-cycle pulse; captures mode_i, period_i, amp_i, offset_i into the pending config
- adc_o  out  WIDTH  signed sample, registered
- valid_o  out  1  adc_o holds a new sample this cycle
- wrap_o  out  1  adc_o is the phase-0 sample of a period

## Operation
- Registers:
  - Active config: mode, P, amp, offset.
  - Pending config plus a pending flag.
  - Phase counter k in 0..P-1.
  - Signed accumulator acc, WIDTH+PERIOD_W+1 bits.
- Reset state:
  - Active config: mode = square, P = 8, amp = 12'h111 (sign-extended/truncated to WIDTH), offset = 0.
  - Pending flag = 0, k = 0, acc = offset.
  - Outputs: adc_o = 0, valid_o = 0, wrap_o = 0.
- Sample value for phase k, with H = P>>1:
  - DC: offset.
  - Square: offset+amp if k<H, else offset.
  - Sawtooth: offset + amp*k.
  - Triangle: offset + amp*k for k≤H; offset + amp*(2H−k) for k>H.
- Implementation of sawtooth and triangle is incremental:
  - Output acc.
  - Then acc += amp (sawtooth, or triangle with k<H), or acc -= amp (triangle with k≥H).
  - acc reloads to offset at wrap.
  - No multipliers or dividers.
- Saturation: every value is clamped to [−2^(WIDTH−1), 2^(WIDTH−1)−1] before it is registered into adc_o. acc itself never wraps within one period.
- Config commit:
  - cfg_load_i sets pending, and the last load wins.
  - Commit (active ← pending, pending ← 0) occurs:
    - at the enabled edge where k = P−1 (k → 0), or
    - at any edge with en_i = 0.
  - If cfg_load_i is high on a commit edge, the inputs present that cycle are committed directly.
  - A committed config always starts at k = 0 with acc = offset.
- A P change never truncates or extends the current period; it takes effect at the next period.

## Timing
- Enabled edge, all in one edge:
  - adc_o ← sample(k) under the active config.
  - valid_o ← 1.
  - wrap_o ← (k == 0).
  - k ← (k+1) mod P.
- Disabled edge: adc_o and k hold; valid_o ← 0; wrap_o ← 0.
- Latency: from en_i rising, the first valid sample appears one cycle later and has the phase held at disable.
- Throughput: one sample per clock while enabled.
- Reset mid-operation: the next edge with rstn_i = 0 restores the full reset state and discards the pending config.
- Reset and cfg_load_i in the same cycle: reset wins.

## Configuration
- ADC_STIM_NOISE_EN defined:
  - A 16-bit Fibonacci LFSR (taps 16,14,13,11) is seeded to 16'hACE1 on reset and advances on every enabled edge.
  - Its low NOISE_BITS bits, sign-extended, are added to the sample before saturation.
- ADC_STIM_NOISE_EN undefined:
  - No LFSR logic is present.
  - Output is exactly the noiseless waveform; NOISE_BITS is ignored.

## Test plan
- Default config: reset, then en_i = 1 → adc_o repeats 0x111 ×4, 0x000 ×4; wrap_o high on each first 0x111; valid_o high every cycle.
- Sawtooth: load mode 2, P = 4, amp = 100, offset = −50 → repeating −50, 50, 150, 250.
- Triangle: load mode 3, P = 6, amp = 10, offset = 0 → repeating 0, 10, 20, 30, 20, 10.
- Saturation and clamp:
  - Sawtooth, P = 4, amp = 2047, offset = 0 → 0, 2047, 2047, 2047.
  - period_i = 0, square, amp = 5 → alternating 5, 0.
- Mid-period load: default square running, cfg_load_i at k = 2 with mode 0, offset = 7 → remaining square samples unchanged; 7 from the next wrap_o onward.
- Enable gaps and reset: drop en_i for 3 cycles at k = 5 → adc_o holds, valid_o = 0, resumes at k = 5. Then assert rstn_i = 0 mid-period → all outputs 0, default config restored, pending load discarded.
